// File: rtl/vtg_pipe_register.sv
// vtg_pipe_register
//   Chain of STAGES registered stages under a valid/ready handshake. Empty
//   stages fill even while the output is stalled (bubble collapse), so up to
//   STAGES words can be held with out_ready low. Ready is combinational
//   through the whole chain; there is no skid buffer.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset: valids cleared, data = RST_VAL
//   flush      synchronous clear of all valid bits; data holds; blocks both
//              handshakes in the cycle it is asserted
//   in_valid   upstream presents in_data
//   in_ready   pipeline accepts in_data this cycle
//   in_data    input word
//   out_valid  out_data is valid (last stage)
//   out_ready  downstream accepts out_data this cycle
//   out_data   last-stage data
//   occupancy  number of valid stages (registered)
module vtg_pipe_register #(
  parameter int               WIDTH   = 8,
  parameter int               STAGES  = 2,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
  parameter int               CNT_W   = $clog2(STAGES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] occupancy
);

  logic [STAGES-1:0] r_v;
  logic [WIDTH-1:0]  r_d [STAGES];
  logic [CNT_W-1:0]  r_occ;

  logic [STAGES:0]   w_rdy;
  logic [STAGES-1:0] w_v_nxt;
  logic [CNT_W-1:0]  w_occ_nxt;

  // The recursive ready r[i] = !v[i] || r[i+1] unrolls to: stage i can take a
  // word when the output drains or some stage from i to the end is empty.
  // Written that way to keep the chain free of a self-referencing vector.
  always_comb begin
    logic w_tail_full;
    w_tail_full   = 1'b1;
    w_rdy         = '0;
    w_rdy[STAGES] = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      w_tail_full = w_tail_full & r_v[i];
      w_rdy[i]    = out_ready | ~w_tail_full;
    end
  end

  always_comb begin
    w_v_nxt = r_v;
    if (flush) begin
      w_v_nxt = '0;
    end else begin
      if (w_rdy[0]) begin
        w_v_nxt[0] = in_valid;
      end
      for (int i = 1; i < STAGES; i++) begin
        if (w_rdy[i]) begin
          w_v_nxt[i] = r_v[i-1];
        end
      end
    end
  end

  // Occupancy is registered alongside the valid bits so it always equals
  // popcount(v) without a separate up/down counter to keep in step.
  always_comb begin
    w_occ_nxt = '0;
    for (int i = 0; i < STAGES; i++) begin
      w_occ_nxt = w_occ_nxt + CNT_W'(w_v_nxt[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v   <= '0;
      r_occ <= '0;
    end else begin
      r_v   <= w_v_nxt;
      r_occ <= w_occ_nxt;
    end
  end

  // Data only moves with a valid word; bubbles leave stale data in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        r_d[i] <= RST_VAL;
      end
    end else if (!flush) begin
      if (w_rdy[0] && in_valid) begin
        r_d[0] <= in_data;
      end
      for (int i = 1; i < STAGES; i++) begin
        if (w_rdy[i] && r_v[i-1]) begin
          r_d[i] <= r_d[i-1];
        end
      end
    end
  end

  assign in_ready  = w_rdy[0] & ~flush;
  // Masked during flush so the word being discarded is never seen as taken.
  assign out_valid = r_v[STAGES-1] & ~flush;
  assign out_data  = r_d[STAGES-1];
  assign occupancy = r_occ;

endmodule

// File: tb/tb_vtg_pipe_register.sv
// Bench for vtg_pipe_register: three instances (STAGES = 3, 4, 1) driven from
// one clock. A slot-level model gives cycle-exact out_valid/out_data/in_ready,
// and a FIFO scoreboard of in-flight words gives ordering and occupancy.
module tb_vtg_pipe_register;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       iv   [3];
  logic       ordy [3];
  logic       fl   [3];
  logic       rs   [3];
  logic [7:0] id   [3];
  logic       o_ir [3];
  logic       o_ov [3];
  logic [7:0] o_od [3];
  logic [1:0] oc0;
  logic [2:0] oc1;
  logic [0:0] oc2;

  vtg_pipe_register #(.WIDTH(8), .STAGES(3), .RST_VAL(8'hA5)) u0 (
    .clk(clk), .rst(rs[0]), .flush(fl[0]), .in_valid(iv[0]), .in_ready(o_ir[0]),
    .in_data(id[0]), .out_valid(o_ov[0]), .out_ready(ordy[0]), .out_data(o_od[0]),
    .occupancy(oc0));
  vtg_pipe_register #(.WIDTH(8), .STAGES(4), .RST_VAL(8'h3C)) u1 (
    .clk(clk), .rst(rs[1]), .flush(fl[1]), .in_valid(iv[1]), .in_ready(o_ir[1]),
    .in_data(id[1]), .out_valid(o_ov[1]), .out_ready(ordy[1]), .out_data(o_od[1]),
    .occupancy(oc1));
  vtg_pipe_register #(.WIDTH(8), .STAGES(1)) u2 (
    .clk(clk), .rst(rs[2]), .flush(fl[2]), .in_valid(iv[2]), .in_ready(o_ir[2]),
    .in_data(id[2]), .out_valid(o_ov[2]), .out_ready(ordy[2]), .out_data(o_od[2]),
    .occupancy(oc2));

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit chk_en = 0;

  function automatic int ns(input int k);
    case (k)
      0: return 3;
      1: return 4;
      default: return 1;
    endcase
  endfunction

  function automatic logic [7:0] rstv(input int k);
    case (k)
      0: return 8'hA5;
      1: return 8'h3C;
      default: return 8'h00;
    endcase
  endfunction

  function automatic int occ(input int k);
    case (k)
      0: return int'(oc0);
      1: return int'(oc1);
      default: return int'(oc2);
    endcase
  endfunction

  task automatic check(input int k, input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL u%0d %s @cyc %0d: actual=%0h required=%0h", k, name, cyc, act, exp);
    end
  endtask

  // In-flight word scoreboard, one FIFO per instance.
  logic [7:0] q0[$], q1[$], q2[$];

  function automatic int sb_size(input int k);
    case (k)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [7:0] sb_front(input int k);
    case (k)
      0: return q0[0];
      1: return q1[0];
      default: return q2[0];
    endcase
  endfunction

  task automatic sb_push(input int k, input logic [7:0] w);
    case (k)
      0: q0.push_back(w);
      1: q1.push_back(w);
      default: q2.push_back(w);
    endcase
  endtask

  task automatic sb_pop(input int k);
    if (sb_size(k) > 0) begin
      case (k)
        0: void'(q0.pop_front());
        1: void'(q1.pop_front());
        default: void'(q2.pop_front());
      endcase
    end
  endtask

  task automatic sb_clear(input int k);
    case (k)
      0: q0.delete();
      1: q1.delete();
      default: q2.delete();
    endcase
  endtask

  // Slot model: a slot can take a word when it is empty or its own word is
  // moving on; the last slot moves on when out_ready is high.
  logic       mv [3][4];
  logic [7:0] md [3][4];

  function automatic logic m_rdy0(input int k);
    logic rdy;
    rdy = ordy[k];
    for (int i = ns(k) - 1; i >= 0; i--) rdy = !mv[k][i] || rdy;
    return rdy;
  endfunction

  task automatic mstep(input int k);
    int   n;
    logic rdy [5];
    logic otx, itx;
    n = ns(k);
    rdy[n] = ordy[k];
    for (int i = n - 1; i >= 0; i--) rdy[i] = !mv[k][i] || rdy[i+1];
    otx = mv[k][n-1] && ordy[k] && !fl[k];
    itx = iv[k] && rdy[0] && !fl[k];
    if (rs[k]) begin
      for (int i = 0; i < 4; i++) begin
        mv[k][i] = 1'b0;
        md[k][i] = rstv(k);
      end
      sb_clear(k);
    end else if (fl[k]) begin
      for (int i = 0; i < 4; i++) mv[k][i] = 1'b0;
      sb_clear(k);
    end else begin
      if (otx) sb_pop(k);
      if (itx) sb_push(k, id[k]);
      for (int i = n - 1; i >= 1; i--) begin
        if (rdy[i]) begin
          if (mv[k][i-1]) md[k][i] = md[k][i-1];
          mv[k][i] = mv[k][i-1];
        end
      end
      if (rdy[0]) begin
        mv[k][0] = iv[k];
        if (iv[k]) md[k][0] = id[k];
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 4; i++) begin
        mv[k][i] = 1'b0;
        md[k][i] = 8'h00;
      end
  end

  always @(posedge clk) begin
    cyc++;
    for (int k = 0; k < 3; k++) mstep(k);
    if (rs[0] && rs[1] && rs[2]) chk_en = 1;
  end

  // Output-transfer logs for the directed literal checks.
  logic [7:0] logd0[$], logd1[$];
  int         logc0[$], logc1[$];

  always @(negedge clk) begin
    if (o_ov[0] && ordy[0]) begin
      logd0.push_back(o_od[0]);
      logc0.push_back(cyc);
    end
    if (o_ov[1] && ordy[1]) begin
      logd1.push_back(o_od[1]);
      logc1.push_back(cyc);
    end
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        logic exp_ov;
        exp_ov = mv[k][ns(k)-1] && !fl[k];
        check(k, "in_ready", int'(o_ir[k]), int'(m_rdy0(k) && !fl[k]));
        check(k, "out_valid", int'(o_ov[k]), int'(exp_ov));
        check(k, "out_data", int'(o_od[k]), int'(md[k][ns(k)-1]));
        check(k, "occupancy", occ(k), sb_size(k));
        if (exp_ov && ordy[k]) begin
          if (sb_size(k) > 0) check(k, "sb_order", int'(o_od[k]), int'(sb_front(k)));
          else check(k, "sb_nonempty", 0, 1);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int acc;

  initial begin
    for (int k = 0; k < 3; k++) begin
      rs[k] = 1'b1; fl[k] = 1'b0;
      iv[k] = 1'($urandom_range(1)); id[k] = 8'($urandom); ordy[k] = 1'($urandom_range(1));
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'($urandom_range(1)); id[k] = 8'($urandom); ordy[k] = 1'($urandom_range(1));
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      rs[k] = 1'b0; iv[k] = 1'b0; ordy[k] = 1'b0; id[k] = 8'h00;
    end
    @(negedge clk);
    check(0, "rst out_valid", int'(o_ov[0]), 0);
    check(0, "rst out_data", int'(o_od[0]), 'hA5);
    check(0, "rst occupancy", occ(0), 0);
    check(0, "rst in_ready", int'(o_ir[0]), 1);
    check(1, "rst out_data", int'(o_od[1]), 'h3C);

    // Streaming 0x01..0x10 through STAGES=3 with out_ready high.
    logd0.delete(); logc0.delete();
    ordy[0] = 1'b1; iv[0] = 1'b1; id[0] = 8'h01;
    tick();
    acc = cyc;
    for (int w = 2; w <= 16; w++) begin
      id[0] = 8'(w);
      tick();
    end
    iv[0] = 1'b0;
    repeat (6) tick();
    check(0, "stream count", logd0.size(), 16);
    if (logc0.size() > 0) check(0, "stream latency", logc0[0] - acc, 2);
    for (int i = 0; i < 16 && i < logd0.size(); i++) begin
      check(0, "stream data", int'(logd0[i]), i + 1);
      check(0, "stream no gap", logc0[i], logc0[0] + i);
    end

    // Backpressure fill.
    logd0.delete(); logc0.delete();
    ordy[0] = 1'b0; iv[0] = 1'b1;
    id[0] = 8'h11; tick();
    id[0] = 8'h22; tick();
    id[0] = 8'h33; tick();
    id[0] = 8'h44;
    @(negedge clk);
    check(0, "bp in_ready full", int'(o_ir[0]), 0);
    check(0, "bp occupancy", occ(0), 3);
    tick();
    ordy[0] = 1'b1;
    @(negedge clk);
    check(0, "bp in_ready release", int'(o_ir[0]), 1);
    tick();
    iv[0] = 1'b0;
    repeat (6) tick();
    check(0, "bp count", logd0.size(), 4);
    for (int i = 0; i < 4 && i < logd0.size(); i++)
      check(0, "bp order", int'(logd0[i]), 'h11 * (i + 1));

    // Bubble collapse on STAGES=4.
    logd1.delete(); logc1.delete();
    ordy[1] = 1'b0; iv[1] = 1'b1; id[1] = 8'h55; tick();
    iv[1] = 1'b0; tick(); tick();
    iv[1] = 1'b1; id[1] = 8'h66; tick();
    iv[1] = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check(1, "bubble occupancy", occ(1), 2);
    check(1, "bubble held valid", int'(o_ov[1]), 1);
    check(1, "bubble held data", int'(o_od[1]), 'h55);
    ordy[1] = 1'b1;
    repeat (6) tick();
    check(1, "bubble count", logd1.size(), 2);
    if (logd1.size() == 2) begin
      check(1, "bubble first", int'(logd1[0]), 'h55);
      check(1, "bubble second", int'(logd1[1]), 'h66);
      check(1, "bubble consecutive", logc1[1], logc1[0] + 1);
    end

    // Flush of a full STAGES=3 pipe with a word presented.
    logd0.delete(); logc0.delete();
    ordy[0] = 1'b0; iv[0] = 1'b1;
    id[0] = 8'h01; tick();
    id[0] = 8'h02; tick();
    id[0] = 8'h03; tick();
    fl[0] = 1'b1; id[0] = 8'h99; ordy[0] = 1'b1;
    @(negedge clk);
    check(0, "flush in_ready", int'(o_ir[0]), 0);
    check(0, "flush out_valid", int'(o_ov[0]), 0);
    tick();
    fl[0] = 1'b0; iv[0] = 1'b0;
    @(negedge clk);
    check(0, "post flush occupancy", occ(0), 0);
    check(0, "post flush out_valid", int'(o_ov[0]), 0);
    tick();
    iv[0] = 1'b1; id[0] = 8'h99;
    @(negedge clk);
    check(0, "re-present in_ready", int'(o_ir[0]), 1);
    tick();
    iv[0] = 1'b0;
    repeat (4) tick();
    check(0, "flush out count", logd0.size(), 1);
    if (logd0.size() == 1) check(0, "flush out word", int'(logd0[0]), 'h99);

    // STAGES=1: continuous in_valid, out_ready alternating.
    for (int c = 0; c < 40; c++) begin
      iv[2] = 1'b1; id[2] = 8'($urandom); ordy[2] = 1'(c % 2);
      @(negedge clk);
      if (c > 0) check(2, "s1 in_ready", int'(o_ir[2]), int'(ordy[2]));
      tick();
    end
    iv[2] = 1'b0; ordy[2] = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check(2, "s1 drained", occ(2), 0);

    // Randomised traffic with occasional flush and reset.
    for (int c = 0; c < 2000; c++) begin
      for (int k = 0; k < 3; k++) begin
        iv[k]   = 1'(($urandom % 4) != 0);
        id[k]   = 8'($urandom);
        ordy[k] = ((c / 200) % 2 == 0) ? 1'(($urandom % 4) != 0) : 1'(($urandom % 4) == 0);
        fl[k]   = 1'(($urandom % 40) == 0);
        rs[k]   = 1'(($urandom % 200) == 0);
      end
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; ordy[k] = 1'b1; fl[k] = 1'b0; rs[k] = 1'b0;
    end
    repeat (8) tick();
    @(negedge clk);
    for (int k = 0; k < 3; k++) check(k, "final drained", occ(k), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
